// File: rtl/mp_arb_pkg.sv
// Shared types and helpers for the mod_power arbiter: FSM encoding, default
// watchdog setting and the round-robin winner search.
package mp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int DEF_TIMEOUT = 0;
    localparam int MAX_REQ     = 8;

    // First set bit of valid searching upward from ptr, wrapping modulo nreq.
    // Returns ptr when nothing is valid; callers qualify with |valid.
    function automatic logic [2:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int                 nreq
    );
        logic [2:0] win;
        logic [2:0] idx;
        logic       found;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = 3'((int'(ptr) + k) % nreq);
            if (!found && (k < nreq) && valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection plus the rotating priority pointer; the pointer
// moves one past the requester whose job just completed.
module rr_arbiter
    import mp_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic [NREQ-1:0] req_valid,
    input  logic            advance,
    input  logic [IDW-1:0]  last_idx,
    output logic            grant_any,
    output logic [IDW-1:0]  grant_idx
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [2:0]         pick;
    logic [IDW-1:0]     rr_ptr_reg;
    logic [IDW-1:0]     rr_ptr_next;

    for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_pad
        if (gi < NREQ) begin : g_used
            assign valid_ext[gi] = req_valid[gi];
        end else begin : g_unused
            assign valid_ext[gi] = 1'b0;
        end
    end

    assign pick      = rr_pick(valid_ext, 3'(rr_ptr_reg), NREQ);
    assign grant_idx = IDW'(pick);
    assign grant_any = |req_valid;

    // Explicit wrap so NREQ need not be a power of two.
    assign rr_ptr_next = (last_idx == IDW'(NREQ - 1)) ? '0 : last_idx + IDW'(1);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rr_ptr_reg <= '0;
        end else if (advance) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/mod_power_arbiter.sv
// Shares one mod_power engine between NREQ requesters: round-robin accept,
// operand latch, launch, watchdog, and result return to the job owner.
module mod_power_arbiter
    import mp_arb_pkg::*;
#(
    parameter int WIDTH       = 512,
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_number,
    input  logic [NREQ*WIDTH-1:0] req_exponent,
    input  logic [NREQ*WIDTH-1:0] req_modules,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      mp_number,
    output logic [WIDTH-1:0]      mp_exponent,
    output logic [WIDTH-1:0]      mp_modules,
    output logic                  mp_start,
    input  logic [WIDTH-1:0]      mp_response,
    input  logic                  mp_done,
    output logic                  busy,
    output logic [IDW-1:0]        owner
);

    localparam int            CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam bit            WD_EN    = (TIMEOUT_CYC > 0);
    localparam logic [CW-1:0] WD_LIMIT = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    arb_state_t       state_reg, state_next;
    logic [IDW-1:0]   owner_reg;
    logic [WIDTH-1:0] mp_number_reg, mp_exponent_reg, mp_modules_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic             rsp_err_reg;
    logic             mp_start_reg;
    logic [CW-1:0]    wd_cnt_reg;

    logic             grant_any;
    logic [IDW-1:0]   grant_idx;
    logic             accept, done_hit, to_hit, resp_ack;

    logic [WIDTH-1:0] num_slot [NREQ];
    logic [WIDTH-1:0] exp_slot [NREQ];
    logic [WIDTH-1:0] mod_slot [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
        assign num_slot[gi]  = req_number[gi*WIDTH +: WIDTH];
        assign exp_slot[gi]  = req_exponent[gi*WIDTH +: WIDTH];
        assign mod_slot[gi]  = req_modules[gi*WIDTH +: WIDTH];
        // Handshake strobes are decoded from the registered owner, so they
        // are one-hot and glitch-free by construction.
        assign req_ready[gi] = (state_reg == ISSUE) && (owner_reg == IDW'(gi));
        assign rsp_valid[gi] = (state_reg == RESP)  && (owner_reg == IDW'(gi));
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .aclk      (aclk),
        .areset    (areset),
        .req_valid (req_valid),
        .advance   (resp_ack),
        .last_idx  (owner_reg),
        .grant_any (grant_any),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        done_hit   = 1'b0;
        to_hit     = 1'b0;
        resp_ack   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_any) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                // Completion takes precedence over a coincident timeout.
                if (mp_done) begin
                    done_hit   = 1'b1;
                    state_next = RESP;
                end else if (WD_EN && (wd_cnt_reg == WD_LIMIT)) begin
                    to_hit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[owner_reg]) begin
                    resp_ack   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg       <= IDLE;
            owner_reg       <= '0;
            mp_number_reg   <= '0;
            mp_exponent_reg <= '0;
            mp_modules_reg  <= '0;
            rsp_data_reg    <= '0;
            rsp_err_reg     <= 1'b0;
            mp_start_reg    <= 1'b0;
            wd_cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            mp_start_reg <= (state_reg == ISSUE);
            if (accept) begin
                owner_reg       <= grant_idx;
                mp_number_reg   <= num_slot[grant_idx];
                mp_exponent_reg <= exp_slot[grant_idx];
                mp_modules_reg  <= mod_slot[grant_idx];
            end
            if (state_reg == ISSUE) begin
                wd_cnt_reg <= '0;
            end else if (state_reg == WAIT) begin
                wd_cnt_reg <= wd_cnt_reg + CW'(1);
            end
            if (done_hit) begin
                rsp_data_reg <= mp_response;
                rsp_err_reg  <= 1'b0;
            end else if (to_hit) begin
                rsp_data_reg <= '0;
                rsp_err_reg  <= 1'b1;
            end
        end
    end

    assign mp_number   = mp_number_reg;
    assign mp_exponent = mp_exponent_reg;
    assign mp_modules  = mp_modules_reg;
    assign mp_start    = mp_start_reg;
    assign rsp_data    = rsp_data_reg;
    assign rsp_err     = rsp_err_reg && (state_reg == RESP);
    assign busy        = (state_reg != IDLE);
    assign owner       = owner_reg;

endmodule

// File: tb/tb_mod_power_arbiter.sv
// Self-checking bench for mod_power_arbiter with a 5-cycle N^E mod M engine model.
module tb_mod_power_arbiter;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int TO    = 8;

    logic                  aclk = 1'b0;
    logic                  areset;
    logic [NREQ-1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*WIDTH-1:0] req_number, req_exponent, req_modules;
    logic [WIDTH-1:0]      rsp_data, mp_number, mp_exponent, mp_modules, mp_response;
    logic                  rsp_err, mp_start, mp_done, busy;
    logic [IDW-1:0]        owner;

    logic                  eng_done, stray_done, eng_enable;
    logic [2:0]            eng_cnt;
    logic [WIDTH-1:0]      eng_res;

    int n_checks = 0;
    int n_fail   = 0;
    int model_ptr = 0;
    logic [WIDTH-1:0] on [NREQ];
    logic [WIDTH-1:0] oe [NREQ];
    logic [WIDTH-1:0] om [NREQ];

    always #5 aclk = ~aclk;

    mod_power_arbiter #(
        .WIDTH       (WIDTH),
        .NREQ        (NREQ),
        .IDW         (IDW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_number   (req_number),
        .req_exponent (req_exponent),
        .req_modules  (req_modules),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .mp_number    (mp_number),
        .mp_exponent  (mp_exponent),
        .mp_modules   (mp_modules),
        .mp_start     (mp_start),
        .mp_response  (mp_response),
        .mp_done      (mp_done),
        .busy         (busy),
        .owner        (owner)
    );

    // Reference arithmetic: plain repeated multiplication.
    function automatic logic [WIDTH-1:0] ref_pow(input int unsigned n, input int unsigned e, input int unsigned m);
        longint unsigned r = 1;
        for (int unsigned i = 0; i < e; i++) r = (r * n) % m;
        r = r % m;
        return WIDTH'(r);
    endfunction

    // Engine arithmetic: square-and-multiply.
    function automatic logic [WIDTH-1:0] eng_pow(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] m);
        longint unsigned r, b;
        if (m == 0) return '0;
        r = 1 % longint'(m);
        b = longint'(n) % longint'(m);
        for (int i = 0; i < WIDTH; i++) begin
            if (e[i]) r = (r * b) % longint'(m);
            b = (b * b) % longint'(m);
        end
        return WIDTH'(r);
    endfunction

    function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Engine: start sampled on a rising edge, done pulses 5 cycles after start rose.
    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            eng_cnt     <= '0;
            eng_done    <= 1'b0;
            eng_res     <= '0;
            mp_response <= '0;
        end else begin
            eng_done <= 1'b0;
            if (mp_start && eng_enable) begin
                eng_cnt <= 3'd4;
                eng_res <= eng_pow(mp_number, mp_exponent, mp_modules);
            end else if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 3'd1;
                if (eng_cnt == 3'd1) begin
                    eng_done    <= 1'b1;
                    mp_response <= eng_res;
                end
            end
        end
    end

    assign mp_done = eng_done | stray_done;

    task automatic set_slot(input int i, input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] e, input logic [WIDTH-1:0] m);
        req_number[i*WIDTH +: WIDTH]   = n;
        req_exponent[i*WIDTH +: WIDTH] = e;
        req_modules[i*WIDTH +: WIDTH]  = m;
        on[i] = n;
        oe[i] = e;
        om[i] = m;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset     = 1'b1;
        req_valid  = '0;
        rsp_ready  = '0;
        stray_done = 1'b0;
        repeat (2) @(negedge aclk);
        areset    = 1'b0;
        model_ptr = 0;
    endtask

    // Drives one job through the handshake and reports what was observed;
    // cycle numbers count negedges from the call, the request being already driven.
    task automatic serve_one(
        input  int              ack_delay,
        input  logic [NREQ-1:0] stray_rdy,
        input  logic [NREQ-1:0] late_valid,
        output int              grant,
        output int              t_ready,
        output int              t_start,
        output int              t_rsp,
        output logic [WIDTH-1:0] data,
        output logic            err,
        output bit              stable,
        output int              extra
    );
        int  t = 0;
        bit  done = 0;
        int  gi;
        grant = -1; t_ready = -1; t_start = -1; t_rsp = -1;
        data = '0; err = 1'b0; stable = 1'b1; extra = 0;
        while (!done && t < 60) begin
            @(negedge aclk);
            t++;
            gi = (grant < 0) ? 0 : grant;
            if (req_ready != 0) begin
                if (t_ready < 0) begin
                    t_ready = t;
                    grant   = onehot_idx(req_ready);
                    gi      = grant;
                    req_valid[gi] = 1'b0;
                    req_valid = req_valid | late_valid;
                end else begin
                    extra++;
                end
            end
            if (mp_start) begin
                if (t_start < 0) t_start = t;
                else extra++;
            end
            if (rsp_valid != 0 && t_rsp < 0) begin
                t_rsp = t;
                data  = rsp_data;
                err   = rsp_err;
            end else if (t_rsp >= 0 && t <= t_rsp + ack_delay) begin
                if (rsp_data !== data || rsp_err !== err || rsp_valid !== NREQ'(1 << gi)) stable = 1'b0;
            end
            if (t_rsp >= 0 && t < t_rsp + ack_delay) begin
                rsp_ready = stray_rdy & ~NREQ'(1 << gi);
            end else if (t_rsp >= 0 && t == t_rsp + ack_delay) begin
                rsp_ready = '0;
                rsp_ready[gi] = 1'b1;
            end else if (t_rsp >= 0 && t == t_rsp + ack_delay + 1) begin
                rsp_ready = '0;
                done = 1;
            end
        end
        rsp_ready = '0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        req_valid = '0; rsp_ready = '0; stray_done = 1'b0; eng_enable = 1'b1;
        req_number = '0; req_exponent = '0; req_modules = '0;
        @(negedge aclk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (req_ready !== '0 || rsp_valid !== '0) begin n_fail++; $display("FAIL reset_handshake: req_ready %b rsp_valid %b expected 0", req_ready, rsp_valid); end
        n_checks++; if (mp_start !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: mp_start %b rsp_err %b expected 0", mp_start, rsp_err); end
        n_checks++; if (owner !== '0) begin n_fail++; $display("FAIL reset_owner: got %0d expected 0", owner); end
        n_checks++; if ({mp_number, mp_exponent, mp_modules, rsp_data} !== '0) begin n_fail++; $display("FAIL reset_data: mp %h %h %h rsp %h expected 0", mp_number, mp_exponent, mp_modules, rsp_data); end
        areset = 1'b0;
        repeat (2) @(negedge aclk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %0b expected 0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_single_job();
        int g, tr, ts, trs, ex; logic [WIDTH-1:0] d; logic e; bit st;
        do_reset();
        set_slot(1, 3, 4, 7);
        req_valid = 4'b0010;
        serve_one(0, '0, '0, g, tr, ts, trs, d, e, st, ex);
        n_checks++; if (g !== 1 || tr !== 1) begin n_fail++; $display("FAIL single_grant: got req %0d at cycle %0d expected req 1 at cycle 1", g, tr); end
        n_checks++; if (ts !== 2) begin n_fail++; $display("FAIL single_start: got cycle %0d expected 2", ts); end
        n_checks++; if (trs !== 8) begin n_fail++; $display("FAIL single_latency: got cycle %0d expected 8", trs); end
        n_checks++; if (d !== ref_pow(3, 4, 7) || e !== 1'b0) begin n_fail++; $display("FAIL single_result: got %0d err %0b expected %0d err 0", d, e, ref_pow(3, 4, 7)); end
        n_checks++; if (ex !== 0) begin n_fail++; $display("FAIL single_pulses: got %0d extra pulses expected 0", ex); end
        model_ptr = 2;
        $display("test_single_job: req %0d result %0d at cycle %0d", g, d, trs);
    endtask

    task automatic test_round_robin();
        int g, tr, ts, trs, ex, expg; logic [WIDTH-1:0] d; logic e; bit st;
        int exp_order [3] = '{0, 2, 3};
        int exp_res   [3] = '{24, 8, 4};
        do_reset();
        set_slot(0, 2, 10, 1000);
        set_slot(2, 5, 3, 13);
        set_slot(3, 3, 4, 7);
        req_valid = 4'b1101;
        for (int j = 0; j < 3; j++) begin
            expg = model_pick(req_valid, model_ptr);
            serve_one($urandom_range(0, 2), '0, '0, g, tr, ts, trs, d, e, st, ex);
            n_checks++; if (g !== exp_order[j] || g !== expg) begin n_fail++; $display("FAIL rr_order_%0d: got req %0d expected %0d", j, g, exp_order[j]); end
            n_checks++; if (d !== WIDTH'(exp_res[j]) || tr !== 1) begin n_fail++; $display("FAIL rr_result_%0d: got %0d at grant cycle %0d expected %0d at 1", j, d, tr, exp_res[j]); end
            model_ptr = (expg + 1) % NREQ;
            $display("test_round_robin: job %0d req %0d result %0d", j, g, d);
        end
        set_slot(1, 2, 3, 5);
        set_slot(0, 4, 2, 9);
        req_valid = 4'b0011;
        serve_one(0, '0, '0, g, tr, ts, trs, d, e, st, ex);
        n_checks++; if (g !== 0) begin n_fail++; $display("FAIL rr_ptr_wrap: got req %0d expected 0", g); end
        serve_one(0, '0, '0, g, tr, ts, trs, d, e, st, ex);
        n_checks++; if (g !== 1 || d !== 16'd3) begin n_fail++; $display("FAIL rr_second: got req %0d result %0d expected req 1 result 3", g, d); end
        model_ptr = 2;
    endtask

    task automatic test_backpressure();
        int g, tr, ts, trs, ex; logic [WIDTH-1:0] d; logic e; bit st;
        set_slot(2, 5, 3, 13);
        set_slot(0, 2, 10, 1000);
        req_valid = 4'b0100;
        serve_one(10, '0, 4'b0001, g, tr, ts, trs, d, e, st, ex);
        n_checks++; if (g !== 2 || d !== 16'd8) begin n_fail++; $display("FAIL bp_first: got req %0d result %0d expected req 2 result 8", g, d); end
        n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable: response changed while held, expected stable"); end
        n_checks++; if (ex !== 0) begin n_fail++; $display("FAIL bp_no_launch: got %0d extra req_ready/mp_start pulses expected 0", ex); end
        $display("test_backpressure: held req %0d result %0d stable %0b", g, d, st);
        serve_one(0, '0, '0, g, tr, ts, trs, d, e, st, ex);
        n_checks++; if (g !== 0 || tr !== 1 || d !== 16'd24) begin n_fail++; $display("FAIL bp_next: got req %0d cycle %0d result %0d expected req 0 cycle 1 result 24", g, tr, d); end
        model_ptr = 1;
    endtask

    task automatic test_timeout();
        int g, tr, ts, trs, ex; logic [WIDTH-1:0] d; logic e; bit st;
        eng_enable = 1'b0;
        set_slot(1, 9, 9, 9);
        req_valid = 4'b0010;
        serve_one(1, '0, '0, g, tr, ts, trs, d, e, st, ex);
        n_checks++; if (e !== 1'b1 || d !== '0) begin n_fail++; $display("FAIL timeout_err: got err %0b data %0d expected err 1 data 0", e, d); end
        n_checks++; if (trs - ts !== TO) begin n_fail++; $display("FAIL timeout_delay: got %0d cycles after start expected %0d", trs - ts, TO); end
        $display("test_timeout: err %0b after %0d cycles", e, trs - ts);
        eng_enable = 1'b1;
        set_slot(3, 7, 5, 11);
        req_valid = 4'b1000;
        serve_one(0, '0, '0, g, tr, ts, trs, d, e, st, ex);
        n_checks++; if (g !== 3 || d !== ref_pow(7, 5, 11) || e !== 1'b0) begin n_fail++; $display("FAIL timeout_recover: got req %0d result %0d err %0b expected req 3 result %0d err 0", g, d, e, ref_pow(7, 5, 11)); end
        model_ptr = 0;
    endtask

    task automatic test_async_reset();
        int g, tr, ts, trs, ex; logic [WIDTH-1:0] d; logic e; bit st;
        set_slot(3, 6, 7, 23);
        req_valid = 4'b1000;
        @(negedge aclk);
        req_valid = '0;
        repeat (3) @(negedge aclk);
        n_checks++; if (busy !== 1'b1 || owner !== 2'd3) begin n_fail++; $display("FAIL areset_pre: busy %0b owner %0d expected busy 1 owner 3", busy, owner); end
        #2 areset = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0 || owner !== '0) begin n_fail++; $display("FAIL areset_now: busy %0b owner %0d expected 0", busy, owner); end
        n_checks++; if ({mp_number, mp_exponent, mp_modules, rsp_data} !== '0 || rsp_valid !== '0 || req_ready !== '0 || mp_start !== 1'b0) begin
            n_fail++; $display("FAIL areset_outputs: mp %h %h %h rsp %h rsp_valid %b expected 0", mp_number, mp_exponent, mp_modules, rsp_data, rsp_valid);
        end
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        model_ptr = 0;
        set_slot(3, 7, 5, 11);
        req_valid = 4'b1000;
        serve_one(0, '0, '0, g, tr, ts, trs, d, e, st, ex);
        n_checks++; if (g !== 3 || d !== ref_pow(7, 5, 11) || trs !== 8) begin n_fail++; $display("FAIL areset_after: got req %0d result %0d cycle %0d expected req 3 result %0d cycle 8", g, d, trs, ref_pow(7, 5, 11)); end
        model_ptr = 0;
        $display("test_async_reset: post-reset req %0d result %0d", g, d);
    endtask

    task automatic test_stray_inputs();
        int g, tr, ts, trs, ex; logic [WIDTH-1:0] d; logic e; bit st;
        stray_done = 1'b1;
        @(negedge aclk);
        stray_done = 1'b0;
        n_checks++; if (busy !== 1'b0 || rsp_valid !== '0) begin n_fail++; $display("FAIL stray_done: busy %0b rsp_valid %b expected 0", busy, rsp_valid); end
        @(negedge aclk);
        n_checks++; if (busy !== 1'b0 || rsp_valid !== '0) begin n_fail++; $display("FAIL stray_done_late: busy %0b rsp_valid %b expected 0", busy, rsp_valid); end
        set_slot(1, 3, 4, 7);
        req_valid = 4'b0010;
        serve_one(4, 4'b1101, '0, g, tr, ts, trs, d, e, st, ex);
        n_checks++; if (g !== 1 || d !== 16'd4 || st !== 1'b1) begin n_fail++; $display("FAIL stray_ready: got req %0d result %0d stable %0b expected req 1 result 4 stable 1", g, d, st); end
        model_ptr = 2;
        $display("test_stray_inputs: req %0d result %0d stable %0b", g, d, st);
    endtask

    task automatic test_random();
        int g, tr, ts, trs, ex, expg, k; logic [WIDTH-1:0] d; logic e; bit st;
        int wait_jobs [NREQ];
        int max_wait = 0;
        for (int i = 0; i < NREQ; i++) wait_jobs[i] = 0;
        req_valid = '0;
        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    set_slot(i, WIDTH'($urandom_range(0, 65535)), WIDTH'($urandom_range(0, 20)), WIDTH'($urandom_range(1, 65535)));
                    req_valid[i] = 1'b1;
                    wait_jobs[i] = 0;
                end
            end
            if (req_valid == '0) begin
                k = $urandom_range(0, NREQ - 1);
                set_slot(k, WIDTH'($urandom_range(0, 65535)), WIDTH'($urandom_range(0, 20)), WIDTH'($urandom_range(1, 65535)));
                req_valid[k] = 1'b1;
                wait_jobs[k] = 0;
            end
            expg = model_pick(req_valid, model_ptr);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && i != expg) begin
                    wait_jobs[i]++;
                    if (wait_jobs[i] > max_wait) max_wait = wait_jobs[i];
                end
            end
            serve_one($urandom_range(0, 3), NREQ'($urandom_range(0, 15)), '0, g, tr, ts, trs, d, e, st, ex);
            n_checks++;
            if (g !== expg || d !== ref_pow(on[expg], oe[expg], om[expg]) || e !== 1'b0) begin
                n_fail++;
                $display("FAIL random_job_%0d: got req %0d result %0d err %0b expected req %0d result %0d err 0", j, g, d, e, expg, ref_pow(on[expg], oe[expg], om[expg]));
            end
            $display("random job %0d: req %0d N=%0d E=%0d M=%0d result %0d", j, g, on[expg], oe[expg], om[expg], d);
            model_ptr = (expg + 1) % NREQ;
        end
        n_checks++; if (max_wait > NREQ - 1) begin n_fail++; $display("FAIL fairness: got wait of %0d jobs expected at most %0d", max_wait, NREQ - 1); end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_async_reset();
        test_stray_inputs();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_power_arbiter.md
Name: mod_power_arbiter

Overview:
Round-robin arbiter and sequencer that shares one mod_power engine between NREQ requesters. Typical requesters are the primality-test rounds, RSA encrypt and RSA decrypt.
The block accepts one operand set (Number, Exponent, Modules), launches the engine, and watches for completion with a watchdog. It returns the result, or a timeout error, to the requester that owns the job.
It sits between the requester FSMs and the single mod_power instance.

Parameters:
WIDTH, 512, operand/result width in bits
NREQ, 4, number of requesters (2..8)
IDW, 2, requester index width; must equal clog2(NREQ)
TIMEOUT_CYC, 0, watchdog limit in cycles; 0 disables the watchdog

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester job request
req_ready  out  NREQ  one-hot; high for one cycle when a job is accepted
req_number  in  NREQ*WIDTH  flattened base operands; slot i is bits [i*WIDTH +: WIDTH]
req_exponent  in  NREQ*WIDTH  flattened exponents
req_modules  in  NREQ*WIDTH  flattened moduli
rsp_valid  out  NREQ  one-hot; result available to the owning requester
rsp_ready  in  NREQ  per-requester result accept
rsp_data  out  WIDTH  result, shared by all requesters; qualified by rsp_valid
rsp_err  out  1  high with rsp_valid when the job timed out
mp_number  out  WIDTH  engine base operand
mp_exponent  out  WIDTH  engine exponent
mp_modules  out  WIDTH  engine modulus
mp_start  out  1  single-cycle engine launch pulse
mp_response  in  WIDTH  engine result
mp_done  in  1  engine completion; sampled only in WAIT
busy  out  1  high in every state except IDLE
owner  out  IDW  index of the current job owner; valid while busy

Behaviour:
- Reset, applied asynchronously:
  - state=IDLE; rr_ptr=0.
  - req_ready, rsp_valid, mp_start, rsp_err, busy all 0; owner=0.
  - mp_number, mp_exponent, mp_modules and rsp_data cleared to 0.
- Reset mid-job: the job is dropped with no response. The engine is reset on the same net by system convention.
- IDLE:
  - If any req_valid bit is set, choose the winner: the first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - Register the winner into owner and latch its three operands into mp_*.
  - Pulse req_ready[winner] for exactly one cycle, then go to ISSUE.
  - Requests that lose arbitration see no req_ready and must hold req_valid.
- ISSUE: mp_start=1 for this one cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - Watchdog counter increments every cycle.
  - On mp_done: latch mp_response into rsp_data, set rsp_err=0, go to RESP.
  - Otherwise, if TIMEOUT_CYC>0 and the counter reaches TIMEOUT_CYC-1: rsp_data=0, rsp_err=1, go to RESP.
  - If mp_done and the timeout occur in the same cycle, mp_done wins.
- RESP:
  - rsp_valid[owner]=1; rsp_data and rsp_err are held stable.
  - On rsp_ready[owner]: clear rsp_valid; set rr_ptr=(owner+1) mod NREQ; go to IDLE.
  - The next grant is decided in the following cycle, so there is one idle bubble between jobs.
- Ignored inputs:
  - mp_done outside WAIT.
  - rsp_ready bits other than the owner's.
  - Changes on req_* after acceptance; operands are latched at acceptance.
- mp_* operand outputs hold their values from acceptance until the next acceptance.
- Minimum latency, req_valid to rsp_valid: 3 cycles + engine latency.
- Fairness: any requester holding req_valid is granted within NREQ jobs.

Decomposition:
- Shared package mp_arb_pkg holds:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3;
  - the DEF_TIMEOUT constant;
  - function rr_pick(valid, ptr), returning the winner index.
- One natural sub-module, rr_arbiter: combinational priority rotation plus the rr_ptr register, instantiated once.
- Operand muxing and the FSM stay in the top level.

Test Plan:
- Config for all scenarios: WIDTH=16, NREQ=4, IDW=2; bench engine model computes N^E mod M with a 5-cycle latency.
- Single job: req 1 sends (3,4,7).
  - Required: req_ready[1] pulses once, then mp_start one cycle later.
  - Required: rsp_valid[1] with rsp_data=4 and rsp_err=0, 8 cycles after the request.
- Round-robin: reqs 0, 2 and 3 valid together with (2,10,1000), (5,3,13) and (3,4,7).
  - Required: grant order 0, 2, 3; results 24, 8, 4.
  - Required: rr_ptr=0 after job 3.
- Backpressure: rsp_ready[2] held low 10 cycles while req 0 is pending.
  - Required: rsp_valid[2] and rsp_data held stable; no mp_start and no req_ready[0] until the response is accepted.
- Timeout: TIMEOUT_CYC=8 and the engine never asserts mp_done.
  - Required: rsp_valid with rsp_err=1 and rsp_data=0, 8 cycles after mp_start.
  - Required: the next request is still served correctly.
- Async reset: assert areset in the middle of WAIT, between clock edges.
  - Required: all outputs return to 0 immediately and busy=0.
  - Required: after release, a new job on req 3 completes with the correct result.
- Stray inputs: pulse mp_done while in IDLE and assert a non-owner rsp_ready during RESP.
  - Required: no state change and no spurious rsp_valid.
